// File: rtl/core_instruction_sequencer.sv
// Instruction feeder: queues instruction words in a circular FIFO and hands
// them to the core one at a time over a start/busy handshake. If the core
// never raises busy after an issue, a sticky timeout flag is set.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | nothing in flight; issue the head entry when queued and core free
// ISSUE    | start is high for this single cycle
// WAIT_ACK | waiting for the core to raise busy, timeout counter running
// RUN      | core executing; wait for busy to fall
module core_instruction_sequencer #(
  parameter int INSTR_WIDTH  = 32,
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pushValid,
  input  logic [INSTR_WIDTH-1:0]       pushInstr,
  output logic                         pushReady,
  input  logic                         flush,
  input  logic                         busy,
  output logic [INSTR_WIDTH-1:0]       instructionOut,
  output logic                         start,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         idle,
  output logic                         timeoutError,
  input  logic                         clearError
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_RUN      = 2'd3;

  logic [1:0]             state;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [TW-1:0]          tmr;
  logic                   do_push;
  logic                   do_pop;
  logic                   timeout_hit;

  // Readiness is a pure function of occupancy, so a pop in the same cycle
  // never makes room for a push into a full queue.
  assign pushReady   = (count < CW'(DEPTH));
  assign do_push     = pushValid && pushReady && !flush;
  assign do_pop      = (state == S_IDLE) && (count != '0) && !busy && !flush;
  assign timeout_hit = (state == S_WAIT_ACK) && !busy && (tmr == TW'(BUSY_TIMEOUT - 1));
  assign idle        = (state == S_IDLE) && (count == '0);

  // Storage array; contents need no reset since count qualifies every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= pushInstr;
    end
  end

  // Queue pointers and occupancy; flush empties the queue but not the in-flight word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue sequencing: one start pulse per instruction, then follow the busy window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      start          <= 1'b0;
      instructionOut <= '0;
      tmr            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (do_pop) begin
            state          <= S_ISSUE;
            start          <= 1'b1;
            instructionOut <= mem[rptr];
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_ACK;
          start <= 1'b0;
          tmr   <= '0;
        end
        S_WAIT_ACK: begin
          if (busy) begin
            state <= S_RUN;
          end else if (timeout_hit) begin
            // The word counts as consumed; it is not re-issued.
            state <= S_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_RUN: begin
          if (!busy) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end

  // Sticky missed-issue flag; a fresh timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeoutError <= 1'b0;
    end else if (timeout_hit) begin
      timeoutError <= 1'b1;
    end else if (clearError) begin
      timeoutError <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_instruction_sequencer.sv
// Bench for core_instruction_sequencer: a cycle table, directed corner-case
// sequences and a randomized run checked against a queue-based model.
module tb_core_instruction_sequencer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          pushValid;
  logic [31:0]   pushInstr;
  logic          pushReady;
  logic          flush;
  logic          busy;
  logic [31:0]   instructionOut;
  logic          start;
  logic [CW-1:0] count;
  logic          idle;
  logic          timeoutError;
  logic          clearError;

  core_instruction_sequencer #(.INSTR_WIDTH(32), .DEPTH(DEPTH), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .pushValid(pushValid), .pushInstr(pushInstr),
    .pushReady(pushReady), .flush(flush), .busy(busy), .instructionOut(instructionOut),
    .start(start), .count(count), .idle(idle), .timeoutError(timeoutError),
    .clearError(clearError)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // reference model: queued words in order, plus a simple core model
  logic [31:0] model_q[$];
  logic [31:0] last_issued;
  logic        sb_en;
  logic        prev_start;
  logic        core_auto;
  logic        core_hold;
  logic        core_pending;
  int          busy_len;
  int          rem;
  int          issues;

  typedef struct packed {
    logic          pv;
    logic [31:0]   pi;
    logic          fl;
    logic          bz;
    logic          st;
    logic [CW-1:0] cnt;
    logic          rdy;
    logic          idl;
    logic [31:0]   io;
  } vec_t;

  vec_t tbl [0:9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=condition-not-met required=condition-met", name);
  endtask

  // one clock: advance, update model and core model, then check outputs
  task automatic step();
    logic acc;
    acc = pushValid && !flush && (model_q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (sb_en) begin
      if (flush) model_q.delete();
      else if (acc) model_q.push_back(pushInstr);
    end
    if (core_hold) begin
      busy = 1'b1;
    end else if (core_pending && core_auto) begin
      busy = 1'b1;
      rem  = busy_len;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) busy = 1'b0;
    end else begin
      busy = 1'b0;
    end
    core_pending = start;
    if (sb_en) begin
      if (start) begin
        chk("start_while_busy", busy, 0);
        if (model_q.size() == 0) begin
          fail("unexpected_start");
        end else begin
          chk("issue_word", instructionOut, model_q[0]);
          last_issued = model_q.pop_front();
        end
        issues++;
      end
      if (start && prev_start) fail("start_single_cycle");
      chk("count", count, model_q.size());
      chk("pushReady", pushReady, (model_q.size() < DEPTH));
      if (busy && !start) chk("instr_stable", instructionOut, last_issued);
    end
    prev_start = start;
  endtask

  task automatic wait_start(input int max);
    int n;
    n = 0;
    while (!start && n < max) begin
      step();
      n++;
    end
    if (!start) fail("wait_start_timeout");
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (!(idle && !busy && rem == 0 && !core_pending) && n < max) begin
      step();
      n++;
    end
    chk("idle_reached", idle, 1);
  endtask

  task automatic push_word(input logic [31:0] w);
    pushValid = 1'b1;
    pushInstr = w;
    step();
    pushValid = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    logic [31:0] prog [4];
    prog[0] = 32'h01200293;
    prog[1] = 32'h01800313;
    prog[2] = 32'h00530e33;
    prog[3] = 32'h000e0fb3;

    reset = 1'b1; pushValid = 1'b0; pushInstr = '0; flush = 1'b0;
    busy = 1'b0; clearError = 1'b0;
    sb_en = 1'b0; prev_start = 1'b0; core_auto = 1'b1; core_hold = 1'b0;
    core_pending = 1'b0; busy_len = 18; rem = 0; issues = 0; last_issued = '0;

    //                 pv    pi            fl    bz    st    cnt   rdy   idl   io
    tbl[0] = '{1'b1, prog[0], 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, prog[0]};
    tbl[2] = '{1'b1, prog[1], 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, prog[0]};
    tbl[3] = '{1'b1, prog[2], 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, prog[0]};
    tbl[4] = '{1'b1, prog[3], 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, prog[0]};
    tbl[5] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, prog[0]};
    tbl[6] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, prog[0]};
    tbl[7] = '{1'b1, prog[1], 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, prog[0]};
    tbl[8] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, prog[0]};
    tbl[9] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, prog[0]};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", start, 0);
    chk("rst_instr", instructionOut, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", pushReady, 1);
    chk("rst_idle", idle, 1);
    chk("rst_err", timeoutError, 0);
    reset = 1'b0;

    // cycle table: latency, flush vs push, flush suppressing issue
    for (int i = 0; i < 10; i++) begin
      pushValid = tbl[i].pv; pushInstr = tbl[i].pi;
      flush = tbl[i].fl; busy = tbl[i].bz;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_start", i), start, tbl[i].st);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_ready", i), pushReady, tbl[i].rdy);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].idl);
      chk($sformatf("tbl%0d_instr", i), instructionOut, tbl[i].io);
    end
    pushValid = 1'b0; flush = 1'b0; busy = 1'b0;
    last_issued = prog[0];
    sb_en = 1'b1;

    // sequential program, 18-cycle busy per instruction
    base = issues;
    busy_len = 18;
    for (int i = 0; i < 4; i++) begin
      pushValid = 1'b1;
      pushInstr = prog[i];
      step();
    end
    pushValid = 1'b0;
    wait_idle(400);
    chk("prog_issue_count", issues - base, 4);

    // fill past capacity with the core held busy, three rounds to wrap pointers
    busy_len = 3;
    for (int r = 0; r < 3; r++) begin
      core_hold = 1'b1;
      busy = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
        if (i == DEPTH) chk("full_ready_low", pushReady, 0);
        pushValid = 1'b1;
        pushInstr = $urandom;
        step();
      end
      pushValid = 1'b0;
      chk("full_count", count, DEPTH);
      base = issues;
      core_hold = 1'b0;
      wait_idle(400);
      chk("full_issue_count", issues - base, DEPTH);
    end

    // timeout: core never raises busy
    core_auto = 1'b0;
    push_word(32'h01200293);
    wait_start(10);
    n = 0;
    while (!timeoutError && n < 40) begin
      step();
      n++;
    end
    chk("timeout_latency", n, 17);
    chk("timeout_idle", idle, 1);
    clearError = 1'b1;
    step();
    clearError = 1'b0;
    chk("timeout_cleared", timeoutError, 0);
    push_word(32'h01800313);
    wait_start(10);
    for (int i = 0; i < 16; i++) step();
    chk("timeout_not_yet", timeoutError, 0);
    clearError = 1'b1;
    step();
    clearError = 1'b0;
    chk("timeout_set_wins", timeoutError, 1);
    clearError = 1'b1;
    step();
    clearError = 1'b0;
    chk("timeout_cleared2", timeoutError, 0);
    core_auto = 1'b1;

    // flush while one instruction is executing
    busy_len = 18;
    base = issues;
    push_word(32'h00000013);
    wait_start(10);
    step();
    for (int i = 0; i < 5; i++) begin
      pushValid = 1'b1;
      pushInstr = 32'h100 + i;
      step();
    end
    chk("flush_pre_count", count, 5);
    flush = 1'b1;
    pushInstr = 32'hdeadbeef;
    step();
    flush = 1'b0;
    pushValid = 1'b0;
    chk("flush_count", count, 0);
    wait_idle(200);
    chk("flush_issue_count", issues - base, 1);

    // async reset during the start-high cycle
    busy_len = 4;
    pushValid = 1'b1;
    pushInstr = 32'h0aaa0001;
    step();
    pushInstr = 32'h0aaa0002;
    step();
    pushValid = 1'b0;
    chk("pre_rst_start", start, 1);
    chk("pre_rst_count", count, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_start", start, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_idle", idle, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
    prev_start = 1'b0; core_pending = 1'b0; rem = 0; busy = 1'b0;
    push_word(32'h01800313);
    chk("post_rst_latency_k", start, 0);
    step();
    chk("post_rst_latency_k1", start, 1);
    chk("post_rst_instr", instructionOut, 32'h01800313);
    wait_idle(100);

    // randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      pushValid = ($urandom_range(0, 1) == 1);
      pushInstr = $urandom;
      flush     = ($urandom_range(0, 39) == 0);
      busy_len  = $urandom_range(1, 4);
      step();
    end
    pushValid = 1'b0;
    flush = 1'b0;
    wait_idle(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
